// File: rtl/bh1750_seq.sv
// BH1750 ambient-light sequencer driving a byte-level I2C master.
// Optional sample averaging is enabled by defining BH1750_AVG_EN.
module bh1750_seq #(
  parameter int unsigned CONTINUOUS   = 0,
  parameter int unsigned MODE         = 0,
  parameter int unsigned T_MEAS_CYC   = 5_000_000,
  parameter int unsigned T_PERIOD_CYC = 25_000_000,
  parameter int unsigned TIMEOUT_CYC  = 1_000_000,
  parameter int unsigned AVG_LOG2     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic        o_i2c_start,
  output logic        o_i2c_rw,
  output logic [7:0]  o_i2c_opcode,
  input  logic        i_i2c_busy,
  input  logic        i_i2c_done,
  input  logic [15:0] i_i2c_data,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_err,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_PWR_DOWN = 3'd0,
    S_PWR_ON   = 3'd1,
    S_RESET    = 3'd2,
    S_CMD      = 3'd3,
    S_MEAS     = 3'd4,
    S_READ     = 3'd5,
    S_IDLE     = 3'd6
  } state_t;

  localparam logic [3:0] HI_NIB =
    (CONTINUOUS != 0) ? 4'h1 : 4'h2;
  localparam logic [3:0] LO_NIB =
    (MODE == 1) ? 4'h1 :
    (MODE == 2) ? 4'h3 : 4'h0;
  localparam logic [7:0] CMD_OP = {HI_NIB, LO_NIB};

  localparam logic [31:0] MEAS_LAST = 32'(T_MEAS_CYC - 1);
  localparam logic [31:0] PER_LAST  = 32'(T_PERIOD_CYC - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic        issued_q;
  logic        pd_done_q;
  logic [31:0] cnt_q;
  logic [31:0] wd_q;

  logic        is_issue;
  logic        waiting;
  logic        got_done;
  logic        timeout;
  logic        enter;
  logic        rd_done;

  logic        start_d;
  logic        rw_d;
  logic [7:0]  op_d;

  assign o_state = state_q;

  always_comb begin
    is_issue = (state_q != S_MEAS) && (state_q != S_IDLE);
    // pd_done marks a finished power-down held while disabled
    waiting  = is_issue && issued_q && !pd_done_q;
    got_done = waiting && i_i2c_done;
    timeout  = waiting && !i_i2c_done && (wd_q == TO_LAST);
    rd_done  = got_done && (state_q == S_READ);
    state_d  = state_q;
    if (timeout) begin
      state_d = S_PWR_DOWN;
    end else begin
      unique case (state_q)
        S_PWR_DOWN:
          if ((got_done || pd_done_q) && i_en)
            state_d = S_PWR_ON;
        S_PWR_ON:
          if (got_done) state_d = S_RESET;
        S_RESET:
          if (got_done) state_d = S_CMD;
        S_CMD:
          if (got_done) state_d = S_MEAS;
        S_MEAS:
          if (cnt_q == MEAS_LAST) state_d = S_READ;
        S_READ:
          if (got_done)
            state_d = i_en ? S_IDLE : S_PWR_DOWN;
        S_IDLE:
          if (cnt_q == PER_LAST) begin
            if (!i_en)
              state_d = S_PWR_DOWN;
            else if (CONTINUOUS != 0)
              state_d = S_MEAS;
            else
              state_d = S_PWR_ON;
          end
        default: state_d = S_PWR_DOWN;
      endcase
    end
    // timeout re-enters PWR_DOWN even from PWR_DOWN
    enter = timeout || (state_d != state_q);
  end

  always_comb begin
    start_d = 1'b0;
    rw_d    = o_i2c_rw;
    op_d    = o_i2c_opcode;
    if (is_issue && !issued_q && !i_i2c_busy) begin
      start_d = 1'b1;
      rw_d    = (state_q == S_READ);
      unique case (1'b1)
        state_q == S_PWR_DOWN: op_d = 8'h00;
        state_q == S_PWR_ON:   op_d = 8'h01;
        state_q == S_RESET:    op_d = 8'h07;
        state_q == S_CMD:      op_d = CMD_OP;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= S_PWR_DOWN;
      issued_q     <= 1'b0;
      pd_done_q    <= 1'b0;
      cnt_q        <= '0;
      wd_q         <= '0;
      o_i2c_start  <= 1'b0;
      o_i2c_rw     <= 1'b0;
      o_i2c_opcode <= 8'h00;
      o_err        <= 1'b0;
    end else begin
      state_q      <= state_d;
      o_i2c_start  <= start_d;
      o_i2c_rw     <= rw_d;
      o_i2c_opcode <= op_d;
      o_err        <= timeout;
      if (enter) begin
        issued_q  <= 1'b0;
        pd_done_q <= 1'b0;
        cnt_q     <= '0;
        wd_q      <= '0;
      end else begin
        cnt_q <= cnt_q + 32'd1;
        if (start_d) begin
          issued_q <= 1'b1;
          wd_q     <= '0;
        end else if (waiting) begin
          wd_q <= wd_q + 32'd1;
        end
        if (got_done && (state_q == S_PWR_DOWN))
          pd_done_q <= 1'b1;
      end
    end
  end

`ifdef BH1750_AVG_EN
  localparam int unsigned AW = 16 + AVG_LOG2;
  localparam logic [4:0] SCNT_LAST =
    5'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_sum;
  logic [4:0]    scnt_q;

  assign acc_sum = acc_q + AW'(i_i2c_data);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      acc_q   <= '0;
      scnt_q  <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (timeout) begin
        acc_q  <= '0;
        scnt_q <= '0;
      end else if (rd_done) begin
        if (scnt_q == SCNT_LAST) begin
          o_data  <= 16'(acc_sum >> AVG_LOG2);
          o_valid <= 1'b1;
          acc_q   <= '0;
          scnt_q  <= '0;
        end else begin
          acc_q  <= acc_sum;
          scnt_q <= scnt_q + 5'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= rd_done;
      if (rd_done) o_data <= i_i2c_data;
    end
  end
`endif

endmodule

// File: tb/tb_bh1750_seq.sv
// Bench for bh1750_seq: one-time and continuous instances,
// each driven by a small I2C master model.
module tb_bh1750_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        en    [2];
  logic        st    [2];
  logic        rwv   [2];
  logic [7:0]  opc   [2];
  logic        busy  [2];
  logic        done  [2];
  logic [15:0] rdat  [2];
  logic [15:0] odat  [2];
  logic        vld   [2];
  logic        err   [2];
  logic [2:0]  sta   [2];
  logic        hold  [2];
  int          mc    [2];
  logic [7:0]  mop   [2];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bh1750_seq #(
    .CONTINUOUS(0), .MODE(0),
    .T_MEAS_CYC(20), .T_PERIOD_CYC(50),
    .TIMEOUT_CYC(100), .AVG_LOG2(2)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .i_en(en[0]),
    .o_i2c_start(st[0]), .o_i2c_rw(rwv[0]),
    .o_i2c_opcode(opc[0]), .i_i2c_busy(busy[0]),
    .i_i2c_done(done[0]), .i_i2c_data(rdat[0]),
    .o_data(odat[0]), .o_valid(vld[0]),
    .o_err(err[0]), .o_state(sta[0])
  );

  bh1750_seq #(
    .CONTINUOUS(1), .MODE(2),
    .T_MEAS_CYC(20), .T_PERIOD_CYC(50),
    .TIMEOUT_CYC(100), .AVG_LOG2(2)
  ) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en[1]),
    .o_i2c_start(st[1]), .o_i2c_rw(rwv[1]),
    .o_i2c_opcode(opc[1]), .i_i2c_busy(busy[1]),
    .i_i2c_done(done[1]), .i_i2c_data(rdat[1]),
    .o_data(odat[1]), .o_valid(vld[1]),
    .o_err(err[1]), .o_state(sta[1])
  );

  // busy from start+1, done pulse at start+5
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      done[g] <= 1'b0;
      if (st[g] === 1'b1) begin
        busy[g] <= 1'b1;
        mc[g]   <= 1;
        mop[g]  <= opc[g];
      end else if (mc[g] != 0) begin
        if (mc[g] == 4) begin
          busy[g] <= 1'b0;
          mc[g]   <= 0;
          done[g] <= !(hold[g] && mop[g] == 8'h01);
        end else begin
          mc[g] <= mc[g] + 1;
        end
      end
    end
  end

  task automatic wait_start(
    input  int         ch,
    input  int         bound,
    output bit         ok,
    output logic [7:0] op,
    output logic       rw,
    output int         waited
  );
    ok = 1'b0; op = 8'h00; rw = 1'b0; waited = 0;
    while (!ok && waited < bound) begin
      @(negedge clk);
      waited++;
      if (st[ch] === 1'b1) begin
        ok = 1'b1; op = opc[ch]; rw = rwv[ch];
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      n_run++;
      if ({st[c], rwv[c], opc[c], odat[c], vld[c],
           err[c], sta[c]} !== 31'd0) begin
        n_fail++;
        $display("FAIL reset_ch%0d: got st=%b rw=%b op=%h data=%h v=%b e=%b s=%0d, exp all 0",
          c, st[c], rwv[c], opc[c], odat[c], vld[c], err[c], sta[c]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_onetime();
    logic [7:0] exp_op [4] = '{8'h00, 8'h01, 8'h07, 8'h20};
    bit ok; logic [7:0] op; logic rw; int w;
    int vc; logic [15:0] val;
    for (int i = 0; i < 4; i++) begin
      wait_start(0, 200, ok, op, rw, w);
      n_run++;
      if (!ok || op !== exp_op[i] || rw !== 1'b0) begin
        n_fail++;
        $display("FAIL onetime_op%0d: got ok=%0d op=%h rw=%b, exp op=%h rw=0",
          i, ok, op, rw, exp_op[i]);
      end
    end
    wait_start(0, 200, ok, op, rw, w);
    rdat[0] = 16'h1234;
    n_run++;
    if (!ok || rw !== 1'b1) begin
      n_fail++;
      $display("FAIL onetime_read: got ok=%0d rw=%b, exp rw=1", ok, rw);
    end
    vc = 0; val = 16'h0;
    repeat (10) begin
      @(negedge clk);
      if (vld[0] === 1'b1) begin vc++; val = odat[0]; end
    end
    n_run++;
    if (vc != 1 || val !== 16'h1234 || sta[0] !== 3'd6) begin
      n_fail++;
      $display("FAIL onetime_data: got valids=%0d data=%h state=%0d, exp 1 1234 6",
        vc, val, sta[0]);
    end
    wait_start(0, 100, ok, op, rw, w);
    n_run++;
    if (!ok || op !== 8'h01 || rw !== 1'b0 || w != 47 || sta[0] !== 3'd1) begin
      n_fail++;
      $display("FAIL onetime_restart: got ok=%0d op=%h rw=%b wait=%0d state=%0d, exp 01 0 47 1",
        ok, op, rw, w, sta[0]);
    end
  endtask

  task automatic test_continuous();
    logic [7:0] exp_op [4] = '{8'h00, 8'h01, 8'h07, 8'h13};
    bit ok; logic [7:0] op; logic rw; int w;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      wait_start(1, 200, ok, op, rw, w);
      n_run++;
      if (!ok || op !== exp_op[i] || rw !== 1'b0) begin
        n_fail++;
        $display("FAIL cont_op%0d: got ok=%0d op=%h rw=%b, exp op=%h rw=0",
          i, ok, op, rw, exp_op[i]);
      end
    end
    wait_start(1, 200, ok, op, rw, w);
    rdat[1] = 16'h0042;
    n_run++;
    if (!ok || rw !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_read0: got ok=%0d rw=%b, exp rw=1", ok, rw);
    end
    for (int i = 1; i < 3; i++) begin
      wait_start(1, 200, ok, op, rw, w);
      n_run++;
      if (!ok || rw !== 1'b1 || w != 77) begin
        n_fail++;
        $display("FAIL cont_read%0d: got ok=%0d rw=%b gap=%0d, exp rw=1 gap=77",
          i, ok, rw, w);
      end
    end
  endtask

  task automatic test_watchdog();
    bit found; int k; bit ok; logic [7:0] op; logic rw; int w;
    found = 1'b0; k = 0;
    for (int t = 0; t < 600 && !found; t++) begin
      @(negedge clk);
      if (st[0] === 1'b1 && opc[0] === 8'h01 && rwv[0] === 1'b0)
        found = 1'b1;
    end
    hold[0] = 1'b1;
    n_run++;
    if (!found) begin
      n_fail++;
      $display("FAIL wd_find: got no PWR_ON start, exp one");
    end
    while (k < 300 && err[0] !== 1'b1) begin
      @(negedge clk); k++;
    end
    hold[0] = 1'b0;
    n_run++;
    if (k != 100) begin
      n_fail++;
      $display("FAIL wd_delay: got %0d cycles, exp 100", k);
    end
    @(negedge clk);
    n_run++;
    if (err[0] !== 1'b0 || st[0] !== 1'b1 || opc[0] !== 8'h00 || sta[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL wd_reinit: got err=%b st=%b op=%h state=%0d, exp 0 1 00 0",
        err[0], st[0], opc[0], sta[0]);
    end
    wait_start(0, 50, ok, op, rw, w);
    n_run++;
    if (!ok || op !== 8'h01) begin
      n_fail++;
      $display("FAIL wd_resume: got ok=%0d op=%h, exp 01", ok, op);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok; logic [7:0] op; logic rw; int w;
    bit got; bit bad; int vc;
    got = 1'b0;
    for (int t = 0; t < 8 && !got; t++) begin
      wait_start(0, 300, ok, op, rw, w);
      if (ok && rw === 1'b1) got = 1'b1;
    end
    n_run++;
    if (!got) begin
      n_fail++;
      $display("FAIL rmr_find: got no read start, exp one");
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_run++;
    if ({st[0], rwv[0], opc[0], odat[0], vld[0],
         err[0], sta[0]} !== 31'd0) begin
      n_fail++;
      $display("FAIL rmr_outputs: got st=%b rw=%b op=%h data=%h v=%b e=%b s=%0d, exp all 0",
        st[0], rwv[0], opc[0], odat[0], vld[0], err[0], sta[0]);
    end
    rst = 1'b1;
    got = 1'b0; bad = 1'b0; vc = 0; w = 0; op = 8'hff;
    while (!got && w < 20) begin
      @(negedge clk); w++;
      if (vld[0] === 1'b1) vc++;
      if (st[0] === 1'b1) begin got = 1'b1; op = opc[0]; end
      if (sta[0] !== 3'd0) bad = 1'b1;
    end
    n_run++;
    if (!got || op !== 8'h00 || w != 3 || bad || vc != 0) begin
      n_fail++;
      $display("FAIL rmr_restart: got ok=%0d op=%h wait=%0d badstate=%0d valids=%0d, exp 00 3 0 0",
        got, op, w, bad, vc);
    end
    wait_start(0, 20, ok, op, rw, w);
    n_run++;
    if (!ok || op !== 8'h01) begin
      n_fail++;
      $display("FAIL rmr_next: got ok=%0d op=%h, exp 01", ok, op);
    end
  endtask

  task automatic test_average();
    logic [15:0] vals [4] = '{16'd100, 16'd101, 16'd102, 16'd104};
    bit ok; logic [7:0] op; logic rw; int w;
    bit got; int vc; logic [15:0] val;
    int exp_vc; logic [15:0] exp_val;
`ifdef BH1750_AVG_EN
    exp_vc = 1; exp_val = 16'd101;
`else
    exp_vc = 4; exp_val = 16'd104;
`endif
    pulse_reset();
    vc = 0; val = 16'h0;
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int t = 0; t < 8 && !got; t++) begin
        wait_start(1, 300, ok, op, rw, w);
        if (ok && rw === 1'b1) got = 1'b1;
      end
      rdat[1] = vals[i];
      n_run++;
      if (!got) begin
        n_fail++;
        $display("FAIL avg_read%0d: got no read start, exp one", i);
      end
      repeat (10) begin
        @(negedge clk);
        if (vld[1] === 1'b1) begin vc++; val = odat[1]; end
      end
    end
    n_run++;
    if (vc != exp_vc || val !== exp_val) begin
      n_fail++;
      $display("FAIL avg_result: got valids=%0d data=%0d, exp %0d %0d",
        vc, val, exp_vc, exp_val);
    end
  endtask

  task automatic test_disable();
    bit ok; logic [7:0] op; logic rw; int w;
    bit found; int ns;
    found = 1'b0;
    for (int t = 0; t < 400 && !found; t++) begin
      @(negedge clk);
      if (sta[0] === 3'd6) found = 1'b1;
    end
    en[0] = 1'b0;
    n_run++;
    if (!found) begin
      n_fail++;
      $display("FAIL dis_idle: got no IDLE, exp state 6");
    end
    wait_start(0, 100, ok, op, rw, w);
    n_run++;
    if (!ok || op !== 8'h00 || rw !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_pwrdown: got ok=%0d op=%h rw=%b, exp 00 0", ok, op, rw);
    end
    ns = 0;
    repeat (1000) begin
      @(negedge clk);
      if (st[0] === 1'b1) ns++;
    end
    n_run++;
    if (ns != 0 || sta[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL dis_hold: got starts=%0d state=%0d, exp 0 0", ns, sta[0]);
    end
    en[0] = 1'b1;
    wait_start(0, 20, ok, op, rw, w);
    n_run++;
    if (!ok || op !== 8'h01) begin
      n_fail++;
      $display("FAIL dis_resume: got ok=%0d op=%h, exp 01", ok, op);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      en[g] = 1'b1; busy[g] = 1'b0; done[g] = 1'b0;
      rdat[g] = 16'h0; hold[g] = 1'b0;
      mc[g] = 0; mop[g] = 8'h00;
    end
    test_reset();
    test_onetime();
    test_continuous();
    test_watchdog();
    test_reset_mid_read();
    test_average();
    test_disable();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/bh1750_seq.md
# bh1750_seq

Parametrised BH1750 ambient-light sequencer. It drives a byte-level I2C master through a start/busy/done handshake: power-down, power-on, register reset, then the measurement command, a conversion wait, and a 16-bit read. Supported modes are one-time and continuous, in H-res, H-res2 or L-res, with optional sample averaging and a transaction watchdog. It sits between the shared I2C master core and display/telemetry consumers of `o_data`.

## Interface
- `CONTINUOUS`, 0: 0 = one-time mode (opcode high nibble 0x2); 1 = continuous mode (high nibble 0x1).
- `MODE`, 0: resolution. 0 = H-res (low nibble 0x0), 1 = H-res2 (0x1), 2 = L-res (0x3), 3 = treated as 0.
- `T_MEAS_CYC`, 5_000_000: conversion wait in cycles, ≥ 1.
- `T_PERIOD_CYC`, 25_000_000: idle gap between samples in cycles, ≥ 1.
- `TIMEOUT_CYC`, 1_000_000: maximum cycles from start pulse to done, ≥ 2.
- `AVG_LOG2`, 2: averaging depth exponent, 0..4.
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, synchronous, active-low.
- `i_en` in 1: when high, run; when low, finish the current transaction, then hold in S_PWR_DOWN.
- `o_i2c_start` out 1: one-cycle transaction request.
- `o_i2c_rw` out 1: 0 = write opcode, 1 = read 2 bytes.
- `o_i2c_opcode` out 8: opcode for writes.
- `i_i2c_busy` in 1: master busy.
- `i_i2c_done` in 1: one-cycle completion pulse.
- `i_i2c_data` in 16: read result, valid on `i_i2c_done` of a read.
- `o_data` out 16: latest (averaged) raw count.
- `o_valid` out 1: one-cycle pulse when `o_data` updates.
- `o_err` out 1: one-cycle pulse on watchdog timeout.
- `o_state` out 3: current state, for debug.

## Operation
- States and encodings: S_PWR_DOWN (0), S_PWR_ON (1), S_RESET (2), S_CMD (3), S_MEAS (4), S_READ (5), S_IDLE (6).
- Opcodes per state:
  - S_PWR_DOWN: 0x00.
  - S_PWR_ON: 0x01.
  - S_RESET: 0x07.
  - S_CMD: {CONTINUOUS ? 4'h1 : 4'h2, low nibble per MODE}.
- Issue states are PWR_DOWN, PWR_ON, RESET, CMD and READ. Each has internal flag `issued`, cleared on state entry.
  - If `!issued && !i_i2c_busy`: pulse `o_i2c_start` and set `issued`.
  - `i_i2c_done` advances the state only while `issued` is 1; otherwise it is ignored.
- Transitions:
  - PWR_DOWN → PWR_ON → RESET → CMD → MEAS.
  - MEAS waits T_MEAS_CYC cycles → READ.
  - READ → IDLE on done.
  - IDLE waits T_PERIOD_CYC cycles. In continuous mode it then goes to MEAS (no re-command). In one-time mode it goes to PWR_ON.
- `i_en` low is sampled on the transition out of IDLE or READ: the block goes to PWR_DOWN and issues 0x00 once, then stays there with no further starts until `i_en` rises.
- Watchdog:
  - A counter runs from the start pulse while waiting for done.
  - When it reaches TIMEOUT_CYC: `o_err` pulses, the accumulator clears, and the state goes to PWR_DOWN (full re-init).
- Counts are 32-bit, compared against param − 1 and zeroed on every state change.
- `o_data` holds its value between updates. It is not cleared by timeout.

## Timing
- Reset values: `o_i2c_start`=0, `o_i2c_rw`=0, `o_i2c_opcode`=0x00, `o_data`=0, `o_valid`=0, `o_err`=0, `o_state`=0. Accumulator, sample count and all counters are 0.
- Reset mid-transaction aborts immediately. A pending done is ignored because `issued` is 0 after reset.
- `o_i2c_rw` and `o_i2c_opcode` are registered and stable from the start-pulse cycle until done.
- Start pulse latency: the first cycle after state entry in which busy is low.
- Done and timeout in the same cycle: done wins, no `o_err`.
- `o_valid` asserts the cycle after the read done that completes a sample (or an average).

## Configuration
- Macro: `BH1750_AVG_EN`.
- Defined:
  - Each read is added to a (16+AVG_LOG2)-bit accumulator.
  - After 2^AVG_LOG2 reads: `o_data` = accumulator >> AVG_LOG2 (truncating), `o_valid` pulses, and the accumulator and count clear.
- Undefined: every read updates `o_data` and pulses `o_valid`; AVG_LOG2 is ignored.

## Test plan
Common bench setup: T_MEAS_CYC=20, T_PERIOD_CYC=50, TIMEOUT_CYC=100. The I2C model goes busy one cycle after start and pulses done 5 cycles after start.

- **One-time H-res, macro off.** Opcode sequence 0x00, 0x01, 0x07, 0x20, then a read. Read returns 0x1234 → `o_data`=0x1234 with one `o_valid` pulse. Next cycle restarts at PWR_ON.
- **Continuous L-res, CONTINUOUS=1, MODE=2.** First command is 0x13. Later samples issue reads only, spaced 50+20 cycles plus transaction time.
- **Averaging, macro on, AVG_LOG2=2.** Reads 100, 101, 102, 104 → a single `o_valid` with `o_data`=101.
- **Watchdog.** Model withholds done on PWR_ON → `o_err` pulses 100 cycles after start, then a new 0x00 is issued.
- **Reset mid-READ.** Assert `i_rst`=0 for one cycle → all outputs at their reset values. Stale done ignored. Sequence restarts with 0x00.
- **Disable.** Drop `i_en` during IDLE → one 0x00 write, then no starts for 1000 cycles. Raising `i_en` resumes at PWR_ON.
